// File: rtl/rk16_pkg.sv
// Shared RK16 core definitions: stage indices, write-back source codes, SP control.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rk16_pkg;

  localparam int XLEN_DEFAULT = 16;

  // Bit positions inside the one-hot stage vector
  localparam int STG_FETCH = 0;
  localparam int STG_RD    = 1;
  localparam int STG_EXE   = 2;
  localparam int STG_WB    = 3;

  // One-hot write-back source selects
  localparam logic [2:0] DIN_ALU  = 3'b001;
  localparam logic [2:0] DIN_MEM  = 3'b010;
  localparam logic [2:0] DIN_LINK = 3'b100;

  typedef enum logic [1:0] {
    SP_NONE = 2'b00,
    SP_PUSH = 2'b01,
    SP_POP  = 2'b10,
    SP_RSVD = 2'b11
  } sp_ctrl_e;

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/rf_din_mux.sv
// Write-back source select: alu result, memory read data or link address (pc+1).
// Latency: purely combinational.
// Backpressure: none; legal=0 flags a din_sel that is not exactly one-hot.
module rf_din_mux
  import rk16_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [2:0]      din_sel,
  input  logic [XLEN-1:0] alu_out,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] din,
  output logic            legal
);

  always_comb begin
    din   = '0;
    legal = 1'b1;
    case (din_sel)
      DIN_ALU:  din = alu_out;
      DIN_MEM:  din = mem_rdata;
      DIN_LINK: din = pc + XLEN'(1);
      default:  legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/rf_wb.sv
// RK16 register file + write-back + stack pointer; optional debug port/counter under RF_DBG_EN.
// Latency: operands latched in the read stage appear next cycle; writes visible from the next read stage.
// Backpressure: hold freezes every state update; a non-one-hot stage vector updates nothing.
module rf_wb
  import rk16_pkg::*;
#(
  parameter int              NREG     = 16,
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter int              SP_IDX   = 1,
  parameter logic [XLEN-1:0] SP_RESET = 16'hFFFF,
  localparam int             AW       = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      stage,
  input  logic            hold,
  input  logic [AW-1:0]   sa1,
  input  logic [AW-1:0]   sa2,
  input  logic [AW-1:0]   da,
  input  logic            we,
  input  logic [2:0]      din_sel,
  input  logic [1:0]      sp_ctrl,
  input  logic [XLEN-1:0] alu_out,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic [XLEN-1:0] pc,
`ifdef RF_DBG_EN
  input  logic [AW-1:0]   dbg_addr,
  output logic [XLEN-1:0] dbg_rdata,
  output logic [15:0]     wb_cnt,
`endif
  output logic [XLEN-1:0] rs1,
  output logic [XLEN-1:0] rs2,
  output logic [XLEN-1:0] sp,
  output logic            wb_err
);

  localparam logic [AW-1:0] SP_ADDR = AW'(SP_IDX);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [XLEN-1:0] rs1_q, rs1_d;
  logic [XLEN-1:0] rs2_q, rs2_d;
  logic            wb_err_q, wb_err_d;

  logic [XLEN-1:0] din;
  logic            din_legal;
  logic            stg_ok;
  logic            rd_en;
  logic            wb_en;
  logic            wr_commit;
  logic            sp_adj;
  sp_ctrl_e        sp_op;

  rf_din_mux #(.XLEN(XLEN)) u_din_mux (
    .din_sel   (din_sel),
    .alu_out   (alu_out),
    .mem_rdata (mem_rdata),
    .pc        (pc),
    .din       (din),
    .legal     (din_legal)
  );

  assign sp_op  = sp_ctrl_e'(sp_ctrl);
  assign stg_ok = is_onehot4(stage) && !hold;
  assign rd_en  = stg_ok && stage[STG_RD];
  assign wb_en  = stg_ok && stage[STG_WB];

  // r0 is hardwired to zero, so a write aimed at it never commits
  assign wr_commit = wb_en && we && din_legal && (da != '0);

  // An explicit write to the SP register takes priority over push/pop
  assign sp_adj = wb_en && ((sp_op == SP_PUSH) || (sp_op == SP_POP)) &&
                  !(wr_commit && (da == SP_ADDR));

  always_comb begin
    regs_d = regs_q;
    if (sp_adj) begin
      if (sp_op == SP_PUSH) regs_d[SP_IDX] = regs_q[SP_IDX] - XLEN'(1);
      else                  regs_d[SP_IDX] = regs_q[SP_IDX] + XLEN'(1);
    end
    if (wr_commit) regs_d[da] = din;
  end

  always_comb begin
    rs1_d = rs1_q;
    rs2_d = rs2_q;
    if (rd_en) begin
      rs1_d = (sa1 == '0) ? '0 : regs_q[sa1];
      rs2_d = (sa2 == '0) ? '0 : regs_q[sa2];
    end
  end

  always_comb begin
    wb_err_d = wb_err_q;
    if (wb_en && we && !din_legal) wb_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= (i == SP_IDX) ? SP_RESET : '0;
      end
      rs1_q    <= '0;
      rs2_q    <= '0;
      wb_err_q <= 1'b0;
    end else begin
      regs_q   <= regs_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      wb_err_q <= wb_err_d;
    end
  end

  assign rs1    = rs1_q;
  assign rs2    = rs2_q;
  assign sp     = regs_q[SP_IDX];
  assign wb_err = wb_err_q;

`ifdef RF_DBG_EN
  logic [15:0] wb_cnt_q, wb_cnt_d;

  always_comb begin
    wb_cnt_d = wb_cnt_q;
    if (wr_commit) wb_cnt_d = wb_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wb_cnt_q <= 16'd0;
    else        wb_cnt_q <= wb_cnt_d;
  end

  assign wb_cnt    = wb_cnt_q;
  assign dbg_rdata = (dbg_addr == '0) ? '0 : regs_q[dbg_addr];
`endif

endmodule

// File: tb/tb_rf_wb.sv
// Bench for rf_wb: table of per-cycle stimulus with expected outputs, checked via a queue.
module tb_rf_wb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  stage;
  logic        hold;
  logic [3:0]  sa1, sa2, da;
  logic        we;
  logic [2:0]  din_sel;
  logic [1:0]  sp_ctrl;
  logic [15:0] alu_out, mem_rdata, pc;
  logic [15:0] rs1, rs2, sp;
  logic        wb_err;
`ifdef RF_DBG_EN
  logic [3:0]  dbg_addr = 4'd0;
  logic [15:0] dbg_rdata;
  logic [15:0] wb_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rf_wb dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .stage     (stage),
    .hold      (hold),
    .sa1       (sa1),
    .sa2       (sa2),
    .da        (da),
    .we        (we),
    .din_sel   (din_sel),
    .sp_ctrl   (sp_ctrl),
    .alu_out   (alu_out),
    .mem_rdata (mem_rdata),
    .pc        (pc),
`ifdef RF_DBG_EN
    .dbg_addr  (dbg_addr),
    .dbg_rdata (dbg_rdata),
    .wb_cnt    (wb_cnt),
`endif
    .rs1       (rs1),
    .rs2       (rs2),
    .sp        (sp),
    .wb_err    (wb_err)
  );

  typedef struct {
    logic [3:0]  stg;
    logic        hold;
    logic [3:0]  sa1, sa2, da;
    logic        we;
    logic [2:0]  dsel;
    logic [1:0]  spc;
    logic [15:0] alu, mem, pc;
    logic [15:0] e_rs1, e_rs2, e_sp;
    logic        e_err;
  } vec_t;

  typedef struct {
    int          idx;
    logic [15:0] rs1, rs2, sp;
    logic        err;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  localparam logic [3:0] F = 4'b0001, R = 4'b0010, E = 4'b0100, W = 4'b1000;

  function automatic vec_t mk(logic [3:0] stg, logic hld, logic [3:0] a1, logic [3:0] a2,
                              logic [3:0] d, logic w, logic [2:0] ds, logic [1:0] sc,
                              logic [15:0] alu, logic [15:0] mem, logic [15:0] p,
                              logic [15:0] r1, logic [15:0] r2, logic [15:0] s, logic e);
    vec_t v;
    v.stg = stg; v.hold = hld; v.sa1 = a1; v.sa2 = a2; v.da = d; v.we = w;
    v.dsel = ds; v.spc = sc; v.alu = alu; v.mem = mem; v.pc = p;
    v.e_rs1 = r1; v.e_rs2 = r2; v.e_sp = s; v.e_err = e;
    return v;
  endfunction

  task automatic check(string name, int idx, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic check_outs(string tag, int idx, logic [15:0] r1, logic [15:0] r2,
                            logic [15:0] s, logic e);
    check({tag, ".rs1"}, idx, rs1, r1);
    check({tag, ".rs2"}, idx, rs2, r2);
    check({tag, ".sp"}, idx, sp, s);
    check({tag, ".wb_err"}, idx, {15'd0, wb_err}, {15'd0, e});
  endtask

  task automatic drive_idle();
    stage = 4'd0; hold = 1'b0; sa1 = 4'd0; sa2 = 4'd0; da = 4'd0; we = 1'b0;
    din_sel = 3'b001; sp_ctrl = 2'b00; alu_out = 16'd0; mem_rdata = 16'd0; pc = 16'd0;
  endtask

  task automatic run_vec(int i);
    exp_t ex;
    vec_t v;
    v = vecs[i];
    @(negedge clk);
    stage = v.stg; hold = v.hold; sa1 = v.sa1; sa2 = v.sa2; da = v.da; we = v.we;
    din_sel = v.dsel; sp_ctrl = v.spc; alu_out = v.alu; mem_rdata = v.mem; pc = v.pc;
    ex.idx = i; ex.rs1 = v.e_rs1; ex.rs2 = v.e_rs2; ex.sp = v.e_sp; ex.err = v.e_err;
    sb.push_back(ex);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard vec %0d: got empty queue expected entry", i);
    end else begin
      ex = sb.pop_front();
      check_outs("vec", ex.idx, ex.rs1, ex.rs2, ex.sp, ex.err);
    end
  endtask

  int n_a;

  initial begin
    // Phase A: functional sequence starting from reset state
    vecs.push_back(mk(W,0, 0,0, 3,1,3'b001,2'b00, 16'h1234,16'h0000,16'h0000, 16'h0000,16'h0000,16'hFFFF,0));
    vecs.push_back(mk(R,0, 3,3, 0,0,3'b001,2'b00, 16'h0000,16'h0000,16'h0000, 16'h1234,16'h1234,16'hFFFF,0));
    vecs.push_back(mk(W,0, 0,0, 0,1,3'b001,2'b00, 16'hBEEF,16'h0000,16'h0000, 16'h1234,16'h1234,16'hFFFF,0));
    vecs.push_back(mk(R,0, 3,0, 0,0,3'b001,2'b00, 16'h0000,16'h0000,16'h0000, 16'h1234,16'h0000,16'hFFFF,0));
    vecs.push_back(mk(W,0, 0,0, 5,1,3'b010,2'b00, 16'h1111,16'hA5A5,16'h0000, 16'h1234,16'h0000,16'hFFFF,0));
    vecs.push_back(mk(W,0, 0,0, 6,1,3'b001,2'b00, 16'h7777,16'h0000,16'h0000, 16'h1234,16'h0000,16'hFFFF,0));
    vecs.push_back(mk(W,0, 0,0, 6,1,3'b100,2'b00, 16'h1111,16'h2222,16'hFFFF, 16'h1234,16'h0000,16'hFFFF,0));
    vecs.push_back(mk(W,0, 0,0, 7,1,3'b100,2'b00, 16'h0000,16'h0000,16'h0010, 16'h1234,16'h0000,16'hFFFF,0));
    vecs.push_back(mk(R,0, 5,6, 0,0,3'b001,2'b00, 16'h0000,16'h0000,16'h0000, 16'hA5A5,16'h0000,16'hFFFF,0));
    vecs.push_back(mk(R,0, 7,5, 0,0,3'b001,2'b00, 16'h0000,16'h0000,16'h0000, 16'h0011,16'hA5A5,16'hFFFF,0));
    vecs.push_back(mk(W,0, 0,0, 0,0,3'b001,2'b10, 16'h0000,16'h0000,16'h0000, 16'h0011,16'hA5A5,16'h0000,0));
    vecs.push_back(mk(W,0, 0,0, 0,0,3'b001,2'b01, 16'h0000,16'h0000,16'h0000, 16'h0011,16'hA5A5,16'hFFFF,0));
    vecs.push_back(mk(W,0, 0,0, 0,0,3'b001,2'b10, 16'h0000,16'h0000,16'h0000, 16'h0011,16'hA5A5,16'h0000,0));
    vecs.push_back(mk(W,0, 0,0, 1,1,3'b001,2'b01, 16'h0040,16'h0000,16'h0000, 16'h0011,16'hA5A5,16'h0040,0));
    vecs.push_back(mk(W,0, 0,0, 2,1,3'b001,2'b01, 16'h2222,16'h0000,16'h0000, 16'h0011,16'hA5A5,16'h003F,0));
    vecs.push_back(mk(R,0, 1,2, 0,0,3'b001,2'b00, 16'h0000,16'h0000,16'h0000, 16'h003F,16'h2222,16'h003F,0));
    vecs.push_back(mk(R,1, 5,6, 0,0,3'b001,2'b00, 16'h0000,16'h0000,16'h0000, 16'h003F,16'h2222,16'h003F,0));
    vecs.push_back(mk(W,1, 0,0, 2,1,3'b001,2'b01, 16'h9999,16'h0000,16'h0000, 16'h003F,16'h2222,16'h003F,0));
    vecs.push_back(mk(R,0, 2,1, 0,0,3'b001,2'b00, 16'h0000,16'h0000,16'h0000, 16'h2222,16'h003F,16'h003F,0));
    vecs.push_back(mk(4'b1010,0, 5,6, 2,1,3'b001,2'b01, 16'h8888,16'h0000,16'h0000, 16'h2222,16'h003F,16'h003F,0));
    vecs.push_back(mk(4'b0000,0, 5,6, 2,1,3'b001,2'b01, 16'h8888,16'h0000,16'h0000, 16'h2222,16'h003F,16'h003F,0));
    vecs.push_back(mk(E,0, 5,6, 2,1,3'b001,2'b01, 16'h8888,16'h0000,16'h0000, 16'h2222,16'h003F,16'h003F,0));
    vecs.push_back(mk(F,0, 5,6, 2,1,3'b001,2'b10, 16'h8888,16'h0000,16'h0000, 16'h2222,16'h003F,16'h003F,0));
    vecs.push_back(mk(W,0, 0,0, 0,0,3'b001,2'b11, 16'h0000,16'h0000,16'h0000, 16'h2222,16'h003F,16'h003F,0));
    vecs.push_back(mk(W,0, 0,0, 2,0,3'b011,2'b00, 16'h5555,16'h0000,16'h0000, 16'h2222,16'h003F,16'h003F,0));
    vecs.push_back(mk(R,0, 2,1, 0,0,3'b001,2'b00, 16'h0000,16'h0000,16'h0000, 16'h2222,16'h003F,16'h003F,0));
    vecs.push_back(mk(W,0, 0,0, 2,1,3'b011,2'b00, 16'h5555,16'h5555,16'h0000, 16'h2222,16'h003F,16'h003F,1));
    vecs.push_back(mk(R,0, 2,5, 0,0,3'b001,2'b00, 16'h0000,16'h0000,16'h0000, 16'h2222,16'hA5A5,16'h003F,1));
    vecs.push_back(mk(W,0, 0,0, 3,1,3'b000,2'b00, 16'h4444,16'h0000,16'h0000, 16'h2222,16'hA5A5,16'h003F,1));
    vecs.push_back(mk(W,0, 0,0, 3,1,3'b111,2'b00, 16'h4444,16'h4444,16'h4444, 16'h2222,16'hA5A5,16'h003F,1));
    vecs.push_back(mk(R,0, 3,2, 0,0,3'b001,2'b00, 16'h0000,16'h0000,16'h0000, 16'h1234,16'h2222,16'h003F,1));
    vecs.push_back(mk(W,0, 0,0, 3,1,3'b001,2'b00, 16'h4321,16'h0000,16'h0000, 16'h1234,16'h2222,16'h003F,1));
    vecs.push_back(mk(R,0, 3,3, 0,0,3'b001,2'b00, 16'h0000,16'h0000,16'h0000, 16'h4321,16'h4321,16'h003F,1));
    n_a = vecs.size();
    // Phase B: after the mid-write-back reset, everything must read back as reset values
    vecs.push_back(mk(R,0, 3,1, 0,0,3'b001,2'b00, 16'h0000,16'h0000,16'h0000, 16'h0000,16'hFFFF,16'hFFFF,0));
    vecs.push_back(mk(R,0, 5,2, 0,0,3'b001,2'b00, 16'h0000,16'h0000,16'h0000, 16'h0000,16'h0000,16'hFFFF,0));
    vecs.push_back(mk(R,0, 6,7, 0,0,3'b001,2'b00, 16'h0000,16'h0000,16'h0000, 16'h0000,16'h0000,16'hFFFF,0));

    drive_idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", -1, 16'h0000, 16'h0000, 16'hFFFF, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < n_a; i++) run_vec(i);

    // Reset lands in the middle of a write-back cycle with a write and push pending
    @(negedge clk);
    stage = W; we = 1'b1; da = 4'd3; din_sel = 3'b001; alu_out = 16'hFFFF; sp_ctrl = 2'b01;
    #2 rst_n = 1'b0;
    #1;
    check_outs("rst_async", -2, 16'h0000, 16'h0000, 16'hFFFF, 1'b0);
    @(posedge clk);
    #1;
    check_outs("rst_held", -3, 16'h0000, 16'h0000, 16'hFFFF, 1'b0);
    @(negedge clk);
    drive_idle();
    rst_n = 1'b1;

    for (int i = n_a; i < vecs.size(); i++) run_vec(i);

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
